// File: rtl/main_file.sv
// main_file: four-contestant quiz buzzer controller.
// Latches the first answering contestant, runs a keypad-preset countdown,
// keeps saturating 0..9 scores and drives an 8-digit multiplexed display.
// Optional feature: define FOUL_DETECT_EN to flag presses made while idle.
module main_file #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int FAST_TICK = 4,
    parameter int SCAN_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       begining,
    input  logic       count_down,
    input  logic       time_select,
    input  logic       Yes,
    input  logic       No,
    input  logic [3:0] row,
    input  logic [3:0] answer,
    input  logic       select1,
    input  logic       select2,
    output logic [3:0] col,
    output logic [7:0] seg_out,
    output logic [7:0] seg_en,
    output logic [3:0] answer_led,
    output logic       alarm
);

    typedef enum logic [1:0] {IDLE, ARMED, LOCKED, TIMEOUT} state_t;

    localparam logic [1:0] MODE_SETUP = 2'b00;
    localparam logic [1:0] MODE_QUIZ  = 2'b01;
    localparam logic [1:0] MODE_SCORE = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    // Lowest set bit index; used for both winner and keypad row decode.
    function automatic logic [1:0] lowest(input logic [3:0] v);
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--) if (v[i]) lowest = 2'(i);
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h3F;  4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;  4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;  4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;  4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;  4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    logic       begining_q, begining_d, count_down_q, time_select_q, time_select_d;
    logic       yes_q, yes_d, no_q, no_d, disp_on;
    logic [3:0] row_q, answer_q;
    logic [1:0] mode_q;
    logic       beg_rise, yes_rise, no_rise;

    // Single register stage on every input, plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            begining_q <= 1'b0; begining_d <= 1'b0; count_down_q <= 1'b0;
            time_select_q <= 1'b0; time_select_d <= 1'b0;
            yes_q <= 1'b0; yes_d <= 1'b0; no_q <= 1'b0; no_d <= 1'b0;
            row_q <= 4'd0; answer_q <= 4'd0; mode_q <= MODE_SETUP; disp_on <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values; blocking here would collapse the delay chain.
            begining_q <= begining;       begining_d <= begining_q;
            count_down_q <= count_down;
            time_select_q <= time_select; time_select_d <= time_select_q;
            yes_q <= Yes;                 yes_d <= yes_q;
            no_q <= No;                   no_d <= no_q;
            row_q <= row; answer_q <= answer; mode_q <= {select1, select2};
            disp_on <= 1'b1;
        end
    end

    assign beg_rise = begining_q & ~begining_d;
    assign yes_rise = yes_q & ~yes_d;
    assign no_rise  = no_q & ~no_d;

    logic [31:0] tick_cnt, tick_period;
    logic        tick;
    assign tick_period = time_select_q ? 32'(CLK_HZ) : 32'(FAST_TICK);
    assign tick        = (tick_cnt == tick_period - 32'd1);

    // Free-running countdown tick; restarts whenever the tick source changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              tick_cnt <= 32'd0;
        else if (time_select_q != time_select_d) tick_cnt <= 32'd0;
        else if (tick)                           tick_cnt <= 32'd0;
        else                                     tick_cnt <= tick_cnt + 32'd1;
    end

    logic [15:0] scan_cnt;
    logic [2:0]  digit_pos;
    logic        step;
    assign step   = (scan_cnt == 16'(SCAN_DIV - 1));
    assign seg_en = 8'b0000_0001 << digit_pos;
    assign col    = 4'b0001 << digit_pos[1:0];

    // Shared scan position: display digit and keypad column advance together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= 16'd0; digit_pos <= 3'd0;
        end else if (step) begin
            scan_cnt <= 16'd0; digit_pos <= digit_pos + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 16'd1;
        end
    end

    logic [6:0] preset;
    logic       key_lock;
    logic [1:0] release_cnt;
    logic [3:0] key_code;
    // row_q was captured while the current column was driven, so column index is digit_pos.
    assign key_code = {lowest(row_q), digit_pos[1:0]};

    // Keypad capture: one key per press, re-armed after a full scan with no rows active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset <= 7'd10; key_lock <= 1'b0; release_cnt <= 2'd0;
        end else if (step) begin
            if (row_q != 4'd0) begin
                release_cnt <= 2'd0;
                if (!key_lock) begin
                    key_lock <= 1'b1;
                    if (mode_q == MODE_SETUP && key_code <= 4'd9)
                        preset <= 7'((preset % 7'd10) * 7'd10 + {3'b000, key_code});
                end
            end else if (key_lock) begin
                if (release_cnt == 2'd3) begin
                    key_lock <= 1'b0; release_cnt <= 2'd0;
                end else begin
                    release_cnt <= release_cnt + 2'd1;
                end
            end
        end
    end

    state_t     state;
    logic [6:0] timer;
    logic [1:0] winner;
    logic [3:0] score [4];
`ifdef FOUL_DETECT_EN
    logic       foul;
    logic [1:0] foul_who;
`endif

    // Round FSM with timer, scores and registered indicator outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE; timer <= 7'd10; winner <= 2'd0;
            answer_led <= 4'd0; alarm <= 1'b0;
            // NOTE: the four score registers are reset explicitly; they are visible state, not scratch storage.
            for (int i = 0; i < 4; i++) score[i] <= 4'd0;
`ifdef FOUL_DETECT_EN
            foul <= 1'b0; foul_who <= 2'd0;
`endif
        end else begin
`ifdef FOUL_DETECT_EN
            answer_led <= foul ? (4'b0001 << foul_who)
                        : (state == LOCKED) ? (4'b0001 << winner) : 4'd0;
            alarm      <= foul || (state == TIMEOUT);
`else
            answer_led <= (state == LOCKED) ? (4'b0001 << winner) : 4'd0;
            alarm      <= (state == TIMEOUT);
`endif
            if (mode_q == MODE_CLEAR)
                for (int i = 0; i < 4; i++) score[i] <= 4'd0;

            if (mode_q != MODE_QUIZ) begin
                state <= IDLE;
`ifdef FOUL_DETECT_EN
                foul <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (beg_rise) begin
                            state <= ARMED; timer <= preset;
`ifdef FOUL_DETECT_EN
                            foul <= 1'b0;
`endif
                        end
`ifdef FOUL_DETECT_EN
                        else if (!foul && answer_q != 4'd0) begin
                            foul <= 1'b1; foul_who <= lowest(answer_q);
                        end
`endif
                    end
                    ARMED: begin
                        if (answer_q != 4'd0) begin
                            state <= LOCKED; winner <= lowest(answer_q);
                        end else if (timer == 7'd0) begin
                            state <= TIMEOUT;
                        end else if (tick && count_down_q) begin
                            timer <= timer - 7'd1;
                        end
                    end
                    LOCKED: begin
                        if (yes_rise) begin
                            if (score[winner] != 4'd9) score[winner] <= score[winner] + 4'd1;
                            state <= IDLE;
                        end else if (no_rise) begin
                            if (score[winner] != 4'd0) score[winner] <= score[winner] - 4'd1;
                            state <= IDLE;
                        end
                    end
                    TIMEOUT: begin
                        if (beg_rise) begin
                            state <= ARMED; timer <= preset;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic [3:0] digit_val;
    logic       digit_blank;

    // Pick the value for the currently enabled digit according to the mode.
    always_comb begin
        // NOTE: defaults first so every path assigns; a missed branch would otherwise infer a latch.
        digit_val   = 4'd0;
        digit_blank = 1'b1;
        case (mode_q)
            MODE_SETUP: begin
                if (digit_pos == 3'd0) begin
                    digit_val = 4'(preset % 7'd10); digit_blank = 1'b0;
                end else if (digit_pos == 3'd1) begin
                    digit_val = 4'(preset / 7'd10); digit_blank = 1'b0;
                end
            end
            MODE_QUIZ: begin
                case (digit_pos)
                    3'd7: begin digit_val = 4'(timer / 7'd10); digit_blank = 1'b0; end
                    3'd6: begin digit_val = 4'(timer % 7'd10); digit_blank = 1'b0; end
                    3'd4: if (state == LOCKED) begin
                        digit_val = {2'b00, winner} + 4'd1; digit_blank = 1'b0;
                    end
                    3'd0, 3'd1, 3'd2, 3'd3: begin
                        digit_val = score[digit_pos[1:0]]; digit_blank = 1'b0;
                    end
                    default: ;
                endcase
            end
            MODE_SCORE: begin
                if (!digit_pos[2]) begin
                    digit_val = score[digit_pos[1:0]]; digit_blank = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Display stays dark until the mode input has been sampled once after reset.
    assign seg_out = (disp_on && !digit_blank) ? {1'b0, seg7(digit_val)} : 8'd0;

endmodule

// File: tb/tb_main_file.sv
// Directed, scoreboard-based bench for main_file (default parameters, FAST_TICK = 4).
module tb_main_file;

    localparam int FAST = 4;

    logic       clk = 1'b0, rst_n = 1'b1;
    logic       begining = 1'b0, count_down = 1'b0, time_select = 1'b0;
    logic       yes_b = 1'b0, no_b = 1'b0, select1 = 1'b0, select2 = 1'b0;
    logic [3:0] row, answer = 4'd0, col, answer_led;
    logic [7:0] seg_out, seg_en;
    logic       alarm;

    logic       key_active = 1'b0;
    logic [1:0] key_row = 2'd0, key_col = 2'd0;

    always #5 clk = ~clk;

    // Keypad model: the held key closes its row only while its column is driven.
    assign row = (key_active && col[key_col]) ? (4'b0001 << key_row) : 4'b0000;

    main_file #(.CLK_HZ(100_000_000), .FAST_TICK(FAST), .SCAN_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .begining(begining), .count_down(count_down),
        .time_select(time_select), .Yes(yes_b), .No(no_b), .row(row),
        .answer(answer), .select1(select1), .select2(select2), .col(col),
        .seg_out(seg_out), .seg_en(seg_en), .answer_led(answer_led), .alarm(alarm)
    );

    typedef struct { string tag; logic [7:0] exp; } exp_t;
    exp_t sb[$];
    int   compared = 0, mismatched = 0;
    int   m_preset = 10;
    int   m_score[4] = '{0, 0, 0, 0};
    logic [7:0] obs;

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: seg_of = 8'h3F; 1: seg_of = 8'h06; 2: seg_of = 8'h5B; 3: seg_of = 8'h4F;
            4: seg_of = 8'h66; 5: seg_of = 8'h6D; 6: seg_of = 8'h7D; 7: seg_of = 8'h07;
            8: seg_of = 8'h7F; 9: seg_of = 8'h6F;
            default: seg_of = 8'h00;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_obs(input logic [7:0] o);
        exp_t e;
        e = sb.pop_front();
        compared++;
        assert (o === e.exp) else begin
            mismatched++;
            $error("FAIL %s: observed %02h expected %02h", e.tag, o, e.exp);
        end
    endtask

    // Wait (bounded) until digit idx is enabled; FF marks "never seen" (dp is always 0).
    task automatic wait_digit(input int idx, output logic [7:0] s);
        s = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (seg_en == (8'b0000_0001 << idx)) begin
                s = seg_out;
                break;
            end
        end
    endtask

    task automatic check_digit(input string tag, input int idx);
        logic [7:0] s;
        wait_digit(idx, s);
        check_obs(s);
    endtask

    task automatic press_key(input int k);
        key_row = 2'(k / 4); key_col = 2'(k % 4); key_active = 1'b1;
        if ({select1, select2} == 2'b00 && k <= 9) m_preset = (m_preset % 10) * 10 + k;
        tick(24);
        key_active = 1'b0;
        tick(24);
    endtask

    task automatic pulse(input int which);
        case (which)
            0: begining = 1'b1;
            1: yes_b = 1'b1;
            default: no_b = 1'b1;
        endcase
        tick(3);
        begining = 1'b0; yes_b = 1'b0; no_b = 1'b0;
        tick(3);
    endtask

    task automatic set_mode(input logic [1:0] m);
        {select1, select2} = m;
        tick(3);
    endtask

    initial begin
        #3 rst_n = 1'b0;
        tick(3);
        push_exp("rst_col", 8'h01);        check_obs({4'b0, col});
        push_exp("rst_seg_en", 8'h01);     check_obs(seg_en);
        push_exp("rst_alarm", 8'h00);      check_obs({7'b0, alarm});
        push_exp("rst_led", 8'h00);        check_obs({4'b0, answer_led});
        push_exp("rst_seg_out", 8'h00);    check_obs(seg_out);
        rst_n = 1'b1;
        tick(2);

        push_exp("setup_d1_reset", seg_of(m_preset / 10)); check_digit("d1", 1);
        push_exp("setup_d0_reset", seg_of(m_preset % 10)); check_digit("d0", 0);

        press_key(3);
        press_key(5);
        push_exp("setup_d1_35", seg_of(m_preset / 10)); check_digit("d1", 1);
        push_exp("setup_d0_35", seg_of(m_preset % 10)); check_digit("d0", 0);

        set_mode(2'b01);
        count_down = 1'b0;
        pulse(0);
        push_exp("quiz_timer_tens", seg_of(m_preset / 10)); check_digit("d7", 7);
        push_exp("quiz_timer_ones", seg_of(m_preset % 10)); check_digit("d6", 6);
        push_exp("quiz_d4_blank", 8'h00);                   check_digit("d4", 4);

        push_exp("lock_led", 8'h02);
        push_exp("lock_d4", seg_of(2));
        answer = 4'b0110;
        tick(3);
        answer = 4'b0000;
        check_obs({4'b0, answer_led});
        check_digit("d4", 4);

        m_score[1] = (m_score[1] < 9) ? m_score[1] + 1 : 9;
        push_exp("yes_led_clear", 8'h00);
        push_exp("yes_score2", seg_of(m_score[1]));
        push_exp("yes_d4_blank", 8'h00);
        pulse(1);
        check_obs({4'b0, answer_led});
        check_digit("d1", 1);
        check_digit("d4", 4);

        set_mode(2'b00);
        press_key(0);
        press_key(2);
        push_exp("setup_d0_02", seg_of(m_preset % 10)); check_digit("d0", 0);
        push_exp("setup_d1_02", seg_of(m_preset / 10)); check_digit("d1", 1);

        set_mode(2'b01);
        count_down = 1'b1;
        push_exp("timeout_alarm", 8'h01);
        begining = 1'b1;
        for (int i = 0; i < 2 * FAST + 3 + 2; i++) begin
            @(negedge clk);
            if (i == 2) begining = 1'b0;
            if (alarm) break;
        end
        begining = 1'b0;
        check_obs({7'b0, alarm});
        push_exp("timeout_led", 8'h00); check_obs({4'b0, answer_led});
        count_down = 1'b0;
        set_mode(2'b00);
        push_exp("leave_quiz_alarm", 8'h00); check_obs({7'b0, alarm});

        set_mode(2'b01);
        pulse(0);
        push_exp("no_led", 8'h01);
        answer = 4'b0001;
        tick(3);
        answer = 4'b0000;
        check_obs({4'b0, answer_led});
        m_score[0] = (m_score[0] > 0) ? m_score[0] - 1 : 0;
        push_exp("no_score1_floor", seg_of(m_score[0]));
        pulse(2);
        check_digit("d0", 0);

        for (int r = 0; r < 10; r++) begin
            pulse(0);
            answer = 4'b0100;
            tick(3);
            answer = 4'b0000;
            m_score[2] = (m_score[2] < 9) ? m_score[2] + 1 : 9;
            pulse(1);
        end
        push_exp("score3_sat9", seg_of(m_score[2])); check_digit("d2", 2);

        set_mode(2'b10);
        for (int i = 0; i < 4; i++) begin
            push_exp($sformatf("score_mode_d%0d", i), seg_of(m_score[i]));
            check_digit("dN", i);
        end

        set_mode(2'b11);
        for (int i = 0; i < 4; i++) m_score[i] = 0;
        push_exp("clear_d0_blank", 8'h00); check_digit("d0", 0);
        push_exp("clear_d7_blank", 8'h00); check_digit("d7", 7);
        set_mode(2'b10);
        push_exp("cleared_d2", seg_of(m_score[2])); check_digit("d2", 2);
        push_exp("cleared_d1", seg_of(m_score[1])); check_digit("d1", 1);

        set_mode(2'b01);
`ifdef FOUL_DETECT_EN
        push_exp("foul_alarm", 8'h01);
        push_exp("foul_led", 8'h01);
`else
        push_exp("idle_press_alarm", 8'h00);
        push_exp("idle_press_led", 8'h00);
`endif
        answer = 4'b0001;
        tick(4);
        answer = 4'b0000;
        tick(1);
        check_obs({7'b0, alarm});
        check_obs({4'b0, answer_led});
        pulse(0);
        push_exp("armed_alarm_clear", 8'h00); check_obs({7'b0, alarm});

        rst_n = 1'b0;
        m_preset = 10;
        tick(1);
        push_exp("midrst_col", 8'h01);    check_obs({4'b0, col});
        push_exp("midrst_seg_en", 8'h01); check_obs(seg_en);
        push_exp("midrst_alarm", 8'h00);  check_obs({7'b0, alarm});
        push_exp("midrst_led", 8'h00);    check_obs({4'b0, answer_led});
        rst_n = 1'b1;
        set_mode(2'b00);
        push_exp("midrst_preset_d1", seg_of(m_preset / 10)); check_digit("d1", 1);
        push_exp("midrst_preset_d0", seg_of(m_preset % 10)); check_digit("d0", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

endmodule
